// File: rtl/pipelined_data_mem.sv
// Purpose: RV32 data memory with funct3 width decode, sign/zero extension, byte-lane stores, self-clear after reset.
// Latency: READ_LATENCY edges from acceptance to the rsp_valid pulse; init takes DEPTH edges after reset release.
// Backpressure: req_ready is low only during the INIT clear; there is no response backpressure.
//
// Ports:
//   clk, reset_n                       - clock, asynchronous active-low reset
//   req_valid/req_ready                - request handshake
//   req_addr, req_we, req_funct3, req_wdata - byte address, store flag, RISC-V width code, LSB-justified store data
//   rsp_valid, rsp_rdata, rsp_err      - one-cycle response pulse, extended load data, error flag
//   init_done                          - array clear finished
module pipelined_data_mem #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          DEPTH        = 1024,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state;
  logic [AW-1:0]         init_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------
  // Init / run FSM. The counter sweeps every word once; the edge that
  // clears the last word also raises ready.
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_INIT;
      init_cnt  <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else if (state == S_INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == AW'(DEPTH - 1)) begin
        state     <= S_RUN;
        req_ready <= 1'b1;
        init_done <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------
  logic [31:0]           offset;
  logic [AW-1:0]         word_idx;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  f3_legal;
  logic                  req_err;
  logic                  accept;
  logic                  st_commit;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] st_word;

  // BASE_ADDR is word aligned, so offset[1:0] equals the address lane bits.
  assign offset   = req_addr - BASE_ADDR;
  assign word_idx = offset[AW+1:2];

  // The explicit below-base test stops the modulo-2^32 offset from
  // wrapping into the array.
  assign out_of_range = (req_addr < BASE_ADDR) ||
                        ({2'b00, offset[31:2]} >= 32'(DEPTH));

  assign misaligned = ((req_funct3[1:0] == 2'b01) && offset[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (offset[1:0] != 2'b00));

  always_comb begin
    f3_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !req_we;  // no unsigned stores
      default:                f3_legal = 1'b0;
    endcase
  end

  assign req_err   = out_of_range || misaligned || !f3_legal;
  assign accept    = req_valid && req_ready;
  assign st_commit = accept && req_we && !req_err;

  // Combinational read of the current array: a store committed on the
  // previous edge is already visible, so no bypass path is needed.
  assign rd_word = mem[word_idx];
  assign rd_byte = rd_word[{offset[1:0], 3'b000} +: 8];
  assign rd_half = rd_word[{offset[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = '0;
    case (req_funct3)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'h0, rd_byte};
      3'b101:  ld_data = {16'h0, rd_half};
      default: ld_data = '0;
    endcase
  end

  // Read-modify-write merge; untouched lanes keep their old contents.
  always_comb begin
    st_word = rd_word;
    case (req_funct3[1:0])
      2'b00:   st_word[{offset[1:0], 3'b000} +: 8] = req_wdata[7:0];
      2'b01:   st_word[{offset[1], 4'b0000} +: 16] = req_wdata[15:0];
      default: st_word = req_wdata;
    endcase
  end

  // Array has no reset; the INIT sweep clears it after every reset.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[init_cnt] <= '0;
    end else if (st_commit) begin
      mem[word_idx] <= st_word;
    end
  end

  // ---------------------------------------------------------------
  // Response pipeline. Err and data are zeroed in non-valid slots so the
  // outputs idle at zero without extra gating.
  // ---------------------------------------------------------------
  logic                  pv [READ_LATENCY];
  logic                  pe [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pd [READ_LATENCY];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pv[i] <= 1'b0;
        pe[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= accept;
      pe[0] <= accept && req_err;
      pd[0] <= (accept && !req_err && !req_we) ? ld_data : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign rsp_valid = pv[READ_LATENCY-1];
  assign rsp_err   = pe[READ_LATENCY-1];
  assign rsp_rdata = pd[READ_LATENCY-1];

endmodule

// File: tb/tb_pipelined_data_mem.sv
// Purpose: directed bench driving three DEPTH=16 instances (latency 1, 3, 4) with one shared request stream.
// Latency: each instance's response is expected READ_LATENCY edges after the acceptance edge.
// Backpressure: requests are presented only once ready is expected; INIT-time requests must be ignored.
module tb_pipelined_data_mem;

  localparam int DEPTH = 16;
  localparam int NEXP  = 1024;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;

  logic [2:0]       rdy;
  logic [2:0]       vld;
  logic [2:0]       er;
  logic [2:0]       done;
  logic [2:0][31:0] rd;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;

  // Expected response per acceptance edge number.
  logic        exp_v [NEXP];
  logic        exp_e [NEXP];
  logic [31:0] exp_d [NEXP];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipelined_data_mem #(
      .DATA_WIDTH  (32),
      .DEPTH       (DEPTH),
      .READ_LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4)),
      .BASE_ADDR   (32'h0000_0000)
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (rdy[g]),
      .req_addr  (req_addr),
      .req_we    (req_we),
      .req_funct3(req_funct3),
      .req_wdata (req_wdata),
      .rsp_valid (vld[g]),
      .rsp_rdata (rd[g]),
      .rsp_err   (er[g]),
      .init_done (done[g])
    );
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < NEXP; i++) begin
      exp_v[i] = 1'b0;
      exp_e[i] = 1'b0;
      exp_d[i] = 32'h0;
    end
  endtask

  // Every cycle, every instance: {valid, err, data} must match the entry
  // for the edge READ_LATENCY-1 edges back, or be all-zero when idle.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        int t;
        logic ev, ee;
        logic [31:0] ed;
        t  = cyc - lat_of(i) + 1;
        ev = (t >= 0) ? exp_v[t % NEXP] : 1'b0;
        ee = ev ? exp_e[t % NEXP] : 1'b0;
        ed = ev ? exp_d[t % NEXP] : 32'h0;
        check($sformatf("rsp_lat%0d_cyc%0d", lat_of(i), cyc),
              {30'h0, vld[i], er[i], rd[i]}, {30'h0, ev, ee, ed});
      end
    end
  end

  // Present one request for the next edge and record its expected response.
  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic xe, input logic [31:0] xd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    exp_v[(cyc + 1) % NEXP] = 1'b1;
    exp_e[(cyc + 1) % NEXP] = xe;
    exp_d[(cyc + 1) % NEXP] = xd;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  // Called just after reset release. A store is held during INIT and must be
  // ignored; ready/init_done must rise exactly on edge DEPTH.
  task automatic wait_init();
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h3C;
    req_wdata  = 32'hBADB_AD00;
    for (int k = 1; k <= DEPTH; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("init_ready%0d_k%0d", i, k), {62'h0, rdy[i], done[i]},
              (k >= DEPTH) ? 64'h3 : 64'h0);
      end
      if (k == DEPTH - 1) req_valid = 1'b0;
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    clear_exp();

    #12;
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_out%0d", i), {28'h0, rdy[i], vld[i], er[i], done[i], rd[i]}, 64'h0);

    #10;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    wait_init();

    // Cleared array, and the INIT-time store was dropped.
    req(1'b0, 3'b010, 32'h3C, 32'h0, 1'b0, 32'h0000_0000);

    // Word round trip, back to back.
    req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
    req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);

    // Byte / half lanes and extension; upper store-data bits must be ignored.
    req(1'b1, 3'b010, 32'h20, 32'h0000_0000, 1'b0, 32'h0);
    req(1'b1, 3'b000, 32'h23, 32'hABCD_EF80, 1'b0, 32'h0);
    req(1'b1, 3'b001, 32'h20, 32'h1234_FFFE, 1'b0, 32'h0);
    req(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h8000_FFFE);
    req(1'b0, 3'b000, 32'h23, 32'h0, 1'b0, 32'hFFFF_FF80);
    req(1'b0, 3'b100, 32'h23, 32'h0, 1'b0, 32'h0000_0080);
    req(1'b0, 3'b001, 32'h20, 32'h0, 1'b0, 32'hFFFF_FFFE);
    req(1'b0, 3'b101, 32'h22, 32'h0, 1'b0, 32'h0000_8000);
    idle(2);

    // Errors; erroneous stores must not touch the array (incl. aliasing to word 0).
    req(1'b0, 3'b010, 32'h02, 32'h0, 1'b1, 32'h0);
    req(1'b0, 3'b001, 32'h01, 32'h0, 1'b1, 32'h0);
    req(1'b1, 3'b010, 32'h3C, 32'h1234_5678, 1'b0, 32'h0);
    req(1'b1, 3'b010, 32'h40, 32'hCAFE_F00D, 1'b1, 32'h0);
    req(1'b0, 3'b010, 32'h3C, 32'h0, 1'b0, 32'h1234_5678);
    req(1'b0, 3'b010, 32'h00, 32'h0, 1'b0, 32'h0000_0000);
    req(1'b0, 3'b111, 32'h00, 32'h0, 1'b1, 32'h0);
    req(1'b1, 3'b100, 32'h04, 32'hFFFF_FFFF, 1'b1, 32'h0);
    req(1'b1, 3'b010, 32'h06, 32'hFFFF_FFFF, 1'b1, 32'h0);
    req(1'b0, 3'b010, 32'h04, 32'h0, 1'b0, 32'h0000_0000);
    req(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0);
    req(1'b0, 3'b101, 32'h03, 32'h0, 1'b1, 32'h0);
    idle(5);

    // Throughput: 8 stores then 8 back-to-back loads.
    for (int i = 0; i < 8; i++)
      req(1'b1, 3'b010, 32'(4 * i), 32'hC0DE_0000 | 32'(i), 1'b0, 32'h0);
    for (int i = 0; i < 8; i++)
      req(1'b0, 3'b010, 32'(4 * i), 32'h0, 1'b0, 32'hC0DE_0000 | 32'(i));
    idle(5);

    // Reset mid-flight: two loads accepted, then a 1 ns reset pulse.
    req(1'b0, 3'b010, 32'h00, 32'h0, 1'b0, 32'hC0DE_0000);
    req(1'b0, 3'b010, 32'h04, 32'h0, 1'b0, 32'hC0DE_0001);
    idle(1);
    #1 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("midreset_out%0d", i), {28'h0, rdy[i], vld[i], er[i], done[i], rd[i]}, 64'h0);
    reset_n = 1'b1;
    clear_exp();
    wait_init();

    // Everything written before the reset is cleared again.
    req(1'b0, 3'b010, 32'h00, 32'h0, 1'b0, 32'h0);
    req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h0);
    req(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h0);
    req(1'b0, 3'b010, 32'h3C, 32'h0, 1'b0, 32'h0);
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_data_mem.md
# pipelined_data_mem

Parametrised, handshaked data memory for the RV32 pipeline core. It replaces the single-cycle combinational-read data memory. It decodes load/store width from funct3, with sign or zero extension and byte-lane stores, and supports a configurable read latency. Misaligned and out-of-range accesses are flagged, and the array is self-cleared after reset. It sits between the core's MEM stage and the backing array and is fully in-order.

## Interface
- DATA_WIDTH, 32: data width in bits; only 32 is legal (RV32).
- DEPTH, 1024: number of 32-bit words; must be a power of two, at least 2.
- READ_LATENCY, 1: edges from acceptance to response; legal range 1..4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.

- clk, input, 1: clock; all state changes on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: module can accept a request this cycle.
- req_addr, input, DATA_WIDTH: byte address.
- req_we, input, 1: 1 = store, 0 = load.
- req_funct3, input, 3: RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_wdata, input, DATA_WIDTH: store data, LSB-justified.
- rsp_valid, output, 1: one-cycle pulse per accepted request.
- rsp_rdata, output, DATA_WIDTH: extended load data; 0 for stores and errors.
- rsp_err, output, 1: misaligned, out-of-range or illegal funct3; qualified by rsp_valid.
- init_done, output, 1: array clear complete.

## Operation
- **FSM states**
  - INIT: on reset release, a word counter writes 0 to words 0..DEPTH-1, one per edge. After the edge that writes word DEPTH-1, the FSM moves to RUN.
  - RUN: req_ready=1 permanently. A request is accepted on any edge where req_valid && req_ready.
  - There is no other state. Requests presented during INIT are ignored (not accepted).
- **Decode**
  - offset = req_addr − BASE_ADDR, computed modulo 2^32.
  - Out of range when req_addr < BASE_ADDR or offset[31:2] ≥ DEPTH.
  - Misaligned when H/HU has addr[0]=1, or W has addr[1:0]≠0.
  - funct3 values 011, 110 and 111 are illegal, as are 100 and 101 for stores.
  - Any of the above sets err=1. An erroneous store does not modify the array.
- **Stores** are committed on the acceptance edge.
  - SB: wdata[7:0] goes to lane addr[1:0].
  - SH: wdata[15:0] goes to lanes {addr[1],0}.
  - SW: all four lanes.
  - Other lanes are unchanged.
- **Loads** read the array as it stands after all previously accepted stores.
  - Lane selection matches stores.
  - B/H results are sign-extended from bit 7/15; BU/HU results are zero-extended.
- **Response pipeline:** READ_LATENCY stages of {valid, err, data}. Each accepted request produces exactly one response, in acceptance order. There is no response backpressure.

## Timing
- **Reset values** (while reset_n=0, asynchronously): req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, FSM=INIT, counter=0, all pipeline valids cleared.
- **Init duration:** the first edge with reset_n=1 clears word 0. Word DEPTH-1 is cleared on edge DEPTH, and init_done=req_ready=1 from that edge onward. DEPTH=1024 therefore takes 1024 cycles.
- **Response latency:** a request accepted at edge t gets rsp_valid=1 for exactly the cycle following edge t+READ_LATENCY−1. For READ_LATENCY=1 that is the cycle immediately after acceptance.
- **Throughput:** one request per cycle, sustained. Back-to-back requests give back-to-back rsp_valid.
- **Ordering:** a store accepted at edge t is visible to a load accepted at edge t+1, with no bypass hazard.
- **Idle output:** when rsp_valid=0, rsp_rdata and rsp_err are 0.
- **Reset mid-operation:** all in-flight responses are discarded with no rsp_valid. The array contents are re-cleared by a new INIT pass.
- **Address wrap:** addresses below BASE_ADDR do not alias. The offset underflow is caught by the req_addr < BASE_ADDR check.

## Test plan
- **Init:** DEPTH=16, release reset_n.
  - req_ready=0 for 16 cycles, then 1.
  - LW at 0x3C returns 0x00000000 with err=0.
- **Word round trip:** READ_LATENCY=3, SW 0xDEADBEEF to 0x10, then LW 0x10 on the next cycle.
  - Two responses, 3 edges after each acceptance.
  - Second response has rdata=0xDEADBEEF.
- **Byte/half extension:** SW 0x00000000 to 0x20, SB 0x80 to 0x23, SH 0xFFFE to 0x20.
  - LW 0x20 returns 0x8000FFFE.
  - LB 0x23 returns 0xFFFFFF80; LBU 0x23 returns 0x00000080.
  - LH 0x20 returns 0xFFFFFFFE; LHU 0x22 returns 0x00008000.
- **Errors:** each returns rsp_err=1 and rdata=0.
  - LW at 0x02, or LH at 0x01.
  - SW to BASE_ADDR+4·DEPTH; a subsequent LW of word DEPTH-1 shows it unchanged.
  - funct3=111.
- **Throughput:** READ_LATENCY=1, 8 consecutive LW 0x00..0x1C after writing distinct values.
  - 8 consecutive rsp_valid cycles with matching data, in order.
- **Reset mid-flight:** READ_LATENCY=4, accept 2 loads, then pulse reset_n low for 1 ns.
  - No rsp_valid appears.
  - req_ready stays 0 for DEPTH cycles.
  - Previously written words read 0 afterwards.
